// File: rtl/memory_controller.sv
// Byte-serial memory controller: turns load/store requests into one RAM byte
// access per cycle, assembling or splitting words and sign/zero-extending loads.
module memory_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [4:0]  oprand,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    input  logic        flush,
    input  logic        io_buffer_full,
    output logic [1:0]  ready,
    output logic [31:0] mem_data,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, IO_WAIT} state_t;

    state_t      state, state_n;
    logic [1:0]  cnt, cnt_n, size_q, size_n, last;
    logic        uns_q, uns_n, done_q, done_n, wr_n;
    logic [31:0] addr_q, addr_n, data_q, data_n, asm_q, asm_n, asm_cap;
    logic [31:0] mem_a_n, mem_data_n;
    logic [7:0]  dout_n;

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz,
                                           input logic u);
        case (sz)
            2'b00:   extend = u ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
            2'b01:   extend = u ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            default: extend = v;
        endcase
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] d, input logic [1:0] idx);
        case (idx)
            2'd0:    byte_of = d[7:0];
            2'd1:    byte_of = d[15:8];
            2'd2:    byte_of = d[23:16];
            default: byte_of = d[31:24];
        endcase
    endfunction

    assign ready = {done_q, state == IDLE};

    always_comb begin
        case (size_q)
            2'b00:   last = 2'd0;
            2'b01:   last = 2'd1;
            default: last = 2'd3;
        endcase
    end

    // Assembly register with the byte arriving this cycle already merged in,
    // so the last byte is part of the value returned on completion.
    always_comb begin
        asm_cap = asm_q;
        case (cnt)
            2'd0:    asm_cap[7:0]   = mem_din;
            2'd1:    asm_cap[15:8]  = mem_din;
            2'd2:    asm_cap[23:16] = mem_din;
            default: asm_cap[31:24] = mem_din;
        endcase
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        size_n     = size_q;
        uns_n      = uns_q;
        addr_n     = addr_q;
        data_n     = data_q;
        asm_n      = asm_q;
        mem_a_n    = mem_a;
        dout_n     = mem_dout;
        wr_n       = mem_wr;
        done_n     = 1'b0;
        mem_data_n = mem_data;
        case (state)
            IDLE: begin
                if (oprand[4] && !flush) begin
                    size_n = oprand[1:0];
                    uns_n  = oprand[2];
                    addr_n = addr;
                    data_n = data;
                    cnt_n  = 2'd0;
                    if (oprand[3]) begin
                        if (addr[17:16] == 2'b11 && io_buffer_full) begin
                            state_n = IO_WAIT;
                        end else begin
                            state_n = WRITE;
                            wr_n    = 1'b1;
                            mem_a_n = addr;
                            dout_n  = data[7:0];
                        end
                    end else begin
                        state_n = READ;
                        mem_a_n = addr;
                        asm_n   = 32'd0;
                    end
                end
            end
            READ: begin
                if (flush) begin
                    state_n = IDLE;
                    mem_a_n = 32'd0;
                    cnt_n   = 2'd0;
                end else begin
                    asm_n = asm_cap;
                    if (cnt == last) begin
                        done_n     = 1'b1;
                        mem_data_n = extend(asm_cap, size_q, uns_q);
                        mem_a_n    = 32'd0;
                        cnt_n      = 2'd0;
                        state_n    = IDLE;
                    end else begin
                        mem_a_n = mem_a + 32'd1;
                        cnt_n   = cnt + 2'd1;
                    end
                end
            end
            WRITE: begin
                if (cnt == last) begin
                    wr_n       = 1'b0;
                    mem_a_n    = 32'd0;
                    dout_n     = 8'd0;
                    done_n     = 1'b1;
                    mem_data_n = 32'd0;
                    cnt_n      = 2'd0;
                    state_n    = IDLE;
                end else begin
                    mem_a_n = mem_a + 32'd1;
                    cnt_n   = cnt + 2'd1;
                    dout_n  = byte_of(data_q, cnt + 2'd1);
                end
            end
            IO_WAIT: begin
                if (!io_buffer_full) begin
                    state_n = WRITE;
                    wr_n    = 1'b1;
                    mem_a_n = addr_q;
                    dout_n  = data_q[7:0];
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            size_q   <= 2'd0;
            uns_q    <= 1'b0;
            addr_q   <= 32'd0;
            data_q   <= 32'd0;
            asm_q    <= 32'd0;
            mem_a    <= 32'd0;
            mem_dout <= 8'd0;
            mem_wr   <= 1'b0;
            done_q   <= 1'b0;
            mem_data <= 32'd0;
        end else if (rdy) begin
            state    <= state_n;
            cnt      <= cnt_n;
            size_q   <= size_n;
            uns_q    <= uns_n;
            addr_q   <= addr_n;
            data_q   <= data_n;
            asm_q    <= asm_n;
            mem_a    <= mem_a_n;
            mem_dout <= dout_n;
            mem_wr   <= wr_n;
            done_q   <= done_n;
            mem_data <= mem_data_n;
        end
    end
endmodule

// File: tb/tb_memory_controller.sv
// Bench for memory_controller: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_memory_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic [4:0]  oprand = 5'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] data = 32'd0;
    logic        flush = 1'b0;
    logic        io_buffer_full = 1'b0;
    logic [1:0]  ready;
    logic [31:0] mem_data;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    memory_controller dut (
        .clk(clk), .rst(rst), .rdy(rdy), .oprand(oprand), .addr(addr), .data(data),
        .flush(flush), .io_buffer_full(io_buffer_full), .ready(ready),
        .mem_data(mem_data), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr)
    );

    // ---------------- clock / RAM ----------------
    always #5 clk = ~clk;

    logic [7:0] ram [0:1023];
    logic       pre_we = 1'b0;
    logic [9:0] pre_a = 10'd0;
    logic [7:0] pre_d = 8'd0;

    always @(posedge clk) begin
        if (pre_we) ram[pre_a] <= pre_d;
        else if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
    end

    always_comb mem_din = ram[mem_a[9:0]];

    // ---------------- behavioural model ----------------
    // kind: 0 idle, 1 load in progress, 2 store on bus, 3 store waiting for I/O buffer
    int          m_kind = 0;
    int          m_k = 0;
    int          m_n = 1;
    logic [31:0] m_base = 32'd0;
    logic [31:0] m_sdata = 32'd0;
    logic        m_uns = 1'b0;
    logic        m_pulse = 1'b0;
    logic [31:0] m_res = 32'd0;

    function automatic logic [31:0] load_value(input logic [31:0] base, input int n,
                                               input logic u);
        logic [31:0] v;
        logic [31:0] a;
        v = 32'd0;
        for (int i = 0; i < n; i++) begin
            a = base + i;
            v = v | (32'(ram[a[9:0]]) << (8 * i));
        end
        if (n == 1 && !u && v[7])  v = v | 32'hFFFF_FF00;
        if (n == 2 && !u && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_kind  = 0;
            m_pulse = 1'b0;
            m_res   = 32'd0;
        end else if (rdy) begin
            logic pulse_n;
            pulse_n = 1'b0;
            case (m_kind)
                0: if (oprand[4] && !flush) begin
                    m_base  = addr;
                    m_sdata = data;
                    m_uns   = oprand[2];
                    m_n     = (oprand[1:0] == 2'b00) ? 1 : (oprand[1:0] == 2'b01) ? 2 : 4;
                    m_k     = 0;
                    if (oprand[3]) m_kind = (addr[17:16] == 2'b11 && io_buffer_full) ? 3 : 2;
                    else m_kind = 1;
                end
                1: if (flush) m_kind = 0;
                   else begin
                       m_k++;
                       if (m_k == m_n) begin
                           pulse_n = 1'b1;
                           m_res   = load_value(m_base, m_n, m_uns);
                           m_kind  = 0;
                       end
                   end
                2: begin
                    m_k++;
                    if (m_k == m_n) begin
                        pulse_n = 1'b1;
                        m_res   = 32'd0;
                        m_kind  = 0;
                    end
                end
                default: if (!io_buffer_full) begin
                    m_kind = 2;
                    m_k    = 0;
                end
            endcase
            m_pulse = pulse_n;
        end
    end

    // ---------------- scoreboard / compare ----------------
    string       name_q[$];
    logic [31:0] act_q[$];
    logic [31:0] exp_q[$];
    int          lit_idx = 0;
    int          n_vec = 0;
    int          n_fail = 0;
    logic        started = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            logic [31:0] e_a;
            logic [7:0]  e_d;
            e_a = (m_kind == 1 || m_kind == 2) ? m_base + m_k : 32'd0;
            e_d = (m_kind == 2) ? 8'(m_sdata >> (8 * m_k)) : 8'd0;
            cmp("ready", {30'd0, ready}, {30'd0, m_pulse, m_kind == 0});
            cmp("mem_a", mem_a, e_a);
            cmp("mem_wr", {31'd0, mem_wr}, {31'd0, m_kind == 2});
            cmp("mem_dout", {24'd0, mem_dout}, {24'd0, e_d});
            if (m_pulse) cmp("mem_data", mem_data, m_res);
        end
        while (lit_idx < exp_q.size()) begin
            cmp(name_q[lit_idx], act_q[lit_idx], exp_q[lit_idx]);
            lit_idx++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        name_q.push_back(nm);
        act_q.push_back(act);
        exp_q.push_back(exp);
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        pre_a  = a[9:0];
        pre_d  = d;
        pre_we = 1'b1;
        tick();
        pre_we = 1'b0;
    endtask

    // Present one request once idle; returns one cycle after the accept edge.
    task automatic issue(input logic st, input logic u, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        int i;
        for (i = 0; i < 50 && !ready[0]; i++) tick();
        if (i == 50) chk("idle_timeout", 32'd0, 32'd1);
        oprand = {1'b1, st, u, sz};
        addr   = a;
        data   = d;
        tick();
        oprand = 5'd0;
    endtask

    task automatic wait_done(output int lat, output logic [31:0] md);
        lat = 0;
        while (!ready[1] && lat < 40) begin
            tick();
            lat++;
        end
        if (!ready[1]) chk("done_timeout", 32'd0, 32'd1);
        md = mem_data;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int          lat;
        logic [31:0] md;
        logic [31:0] wd;
        logic [31:0] ra;

        for (int i = 0; i < 1024; i++) poke(i, 8'($urandom_range(0, 255)));
        started = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_ready", {30'd0, ready}, 32'd1);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_mem_data", mem_data, 32'd0);

        // word load 0x100 -> 0x12345678
        poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
        issue(1'b0, 1'b0, 2'b10, 32'h100, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("lw_mem_a", mem_a, 32'h100 + i);
            tick();
        end
        chk("lw_ready", {30'd0, ready}, 32'd3);
        chk("lw_data", mem_data, 32'h1234_5678);

        // LB / LBU / LH wrapping
        poke(32'h80, 8'h80);
        issue(1'b0, 1'b0, 2'b00, 32'h80, 32'd0);
        wait_done(lat, md);
        chk("lb_lat", lat, 32'd1);
        chk("lb_data", md, 32'hFFFF_FF80);
        issue(1'b0, 1'b1, 2'b00, 32'h80, 32'd0);
        wait_done(lat, md);
        chk("lbu_data", md, 32'h0000_0080);
        poke(32'hFFFF_FFFF, 8'h01); poke(32'h0, 8'h80);
        issue(1'b0, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'd0);
        chk("lh_a0", mem_a, 32'hFFFF_FFFF);
        tick();
        chk("lh_a1_wrap", mem_a, 32'd0);
        wait_done(lat, md);
        chk("lh_data", md, 32'hFFFF_8001);

        // SW 0x200
        wd = 32'hAABB_CCDD;
        issue(1'b1, 1'b0, 2'b10, 32'h200, wd);
        for (int i = 0; i < 4; i++) begin
            chk("sw_mem_a", mem_a, 32'h200 + i);
            chk("sw_mem_wr", {31'd0, mem_wr}, 32'd1);
            chk("sw_dout", {24'd0, mem_dout}, {24'd0, wd[8*i +: 8]});
            tick();
        end
        chk("sw_ready", {30'd0, ready}, 32'd3);
        chk("sw_data", mem_data, 32'd0);

        // flush at c+2 of word load
        issue(1'b0, 1'b0, 2'b10, 32'h100, 32'd0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_ready", {30'd0, ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("fl_no_pulse", {31'd0, ready[1]}, 32'd0);
            tick();
        end

        // flush during SH has no effect
        issue(1'b1, 1'b0, 2'b01, 32'h40, 32'h0000_1234);
        flush = 1'b1;
        wait_done(lat, md);
        flush = 1'b0;
        chk("sh_fl_lat", lat, 32'd2);
        tick();
        chk("sh_fl_b0", {24'd0, ram[10'h40]}, 32'h34);
        chk("sh_fl_b1", {24'd0, ram[10'h41]}, 32'h12);

        // I/O store held by a full buffer
        io_buffer_full = 1'b1;
        issue(1'b1, 1'b0, 2'b00, 32'h0003_0000, 32'h0000_005A);
        for (int i = 0; i < 3; i++) begin
            chk("io_hold_wr", {31'd0, mem_wr}, 32'd0);
            tick();
        end
        io_buffer_full = 1'b0;
        tick();
        chk("io_wr", {31'd0, mem_wr}, 32'd1);
        chk("io_a", mem_a, 32'h0003_0000);
        chk("io_dout", {24'd0, mem_dout}, 32'h5A);
        tick();
        chk("io_ready", {30'd0, ready}, 32'd3);
        chk("io_wr_off", {31'd0, mem_wr}, 32'd0);

        // rdy low for 2 cycles mid-load
        issue(1'b0, 1'b0, 2'b10, 32'h100, 32'd0);
        tick();
        rdy = 1'b0;
        tick();
        tick();
        rdy = 1'b1;
        wait_done(lat, md);
        chk("stall_lat", lat + 3, 32'd6);
        chk("stall_data", md, 32'h1234_5678);

        // reset in the middle of a word store
        issue(1'b1, 1'b0, 2'b10, 32'h200, 32'h1122_3344);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ready", {30'd0, ready}, 32'd1);
        chk("mid_rst_wr", {31'd0, mem_wr}, 32'd0);
        chk("mid_rst_a", mem_a, 32'd0);
        chk("mid_rst_dout", {24'd0, mem_dout}, 32'd0);
        chk("mid_rst_data", mem_data, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("mid_rst_no_pulse", {31'd0, ready[1]}, 32'd0);
            tick();
        end

        // random traffic, checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            rdy            = ($urandom_range(0, 9) != 0);
            flush          = ($urandom_range(0, 19) == 0);
            io_buffer_full = ($urandom_range(0, 2) == 0);
            rst            = ($urandom_range(0, 299) == 0);
            case ($urandom_range(0, 3))
                0:       ra = 32'hFFFF_FFFC + $urandom_range(0, 3);
                1:       ra = 32'h0003_0000 | $urandom_range(0, 1023);
                default: ra = $urandom;
            endcase
            addr   = ra;
            data   = $urandom;
            oprand = 5'($urandom_range(0, 31));
            tick();
        end
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0; oprand = 5'd0;
        for (int i = 0; i < 20; i++) tick();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
